absorb_load_stage: RTL and testbench

- First pipeline stage of the SHAKE core, upstream of the permute/dump stage.
- Accepts the message as W-bit words over a valid/ready handshake and packs them into a rate-wide block register.
- Applies SHAKE padding, then hands the block, output_size and operation_mode to the permute stage via the input_buffer_ready / last_block_in_buffer flag pair, which the permute stage clears.

---
 rtl/absorb_load_stage.sv | 196 +++++++++++++++++++
 tb/tb_absorb_load_stage.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/absorb_load_stage.sv
// absorb_load_stage: packs message words into a rate-wide block,
// applies SHAKE padding and hands blocks to the permute stage.
module absorb_load_stage #(
  parameter int W       = 64,
  parameter int RATE128 = 1344,
  parameter int RATE256 = 1088
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             data_in,
  input  logic                     valid_in,
  input  logic                     last_in,
  input  logic [$clog2(W/8):0]     last_bytes,
  input  logic [31:0]              output_size_in,
  input  logic [1:0]               operation_mode_in,
  output logic                     ready_out,
  output logic [RATE128-1:0]       rate_output,
  output logic [31:0]              output_size,
  output logic [1:0]               operation_mode,
  output logic                     input_buffer_ready,
  output logic                     last_block_in_buffer,
  input  logic                     input_buffer_ready_clr,
  input  logic                     last_block_in_buffer_clr
);

  localparam int NB   = W / 8;
  localparam int LBW  = $clog2(NB) + 1;
  localparam int NW1  = RATE128 / W;
  localparam int NW2  = RATE256 / W;
  localparam int CW   = $clog2(NW1 + 1);
  localparam int NBY1 = RATE128 / 8;
  localparam int NBY2 = RATE256 / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FINAL, S_WMID, S_WPAD, S_WEND
  } state_t;

  state_t             r_state;
  state_t             w_nxt;
  logic [CW-1:0]      r_cnt;
  logic [LBW-1:0]     r_lb;
  logic [RATE128-1:0] r_rate;
  logic [31:0]        r_size;
  logic [1:0]         r_mode;
  logic               r_ibr;
  logic               r_lbb;
  logic               r_ready;

  logic               w_hs;
  logic               w_is256;
  logic [CW-1:0]      w_nw_last;
  logic [15:0]        w_nbytes;
  logic [15:0]        w_pos;
  logic               w_in_blk;
  logic               w_ibr_done;
  logic               w_lbb_done;
  logic [RATE128-1:0] w_fin;
  logic [RATE128-1:0] w_pad;

  assign w_hs       = valid_in && r_ready;
  assign w_is256    = (r_mode == 2'b01);
  assign w_nw_last  = w_is256 ? CW'(NW2 - 1) : CW'(NW1 - 1);
  assign w_nbytes   = w_is256 ? 16'(NBY2) : 16'(NBY1);
  assign w_pos      = 16'(r_cnt) * 16'(NB) + 16'(r_lb);
  assign w_in_blk   = (w_pos < w_nbytes);
  assign w_ibr_done = !r_ibr || input_buffer_ready_clr;
  assign w_lbb_done = !r_lbb || last_block_in_buffer_clr;

  assign ready_out            = r_ready;
  assign rate_output          = r_rate;
  assign output_size          = r_size;
  assign operation_mode       = r_mode;
  assign input_buffer_ready   = r_ibr;
  assign last_block_in_buffer = r_lbb;

  // Padded final block and the standalone padding block.
  always_comb begin
    w_fin = r_rate;
    w_pad = '0;
    for (int b = 0; b < NBY1; b++) begin
      if (16'(b) >= w_pos)
        w_fin[b*8 +: 8] = 8'h00;
      if (16'(b) == w_pos && w_in_blk)
        w_fin[b*8 +: 8] = 8'h1F;
      if (16'(b) == w_nbytes - 16'd1) begin
        if (w_in_blk)
          w_fin[b*8 +: 8] = w_fin[b*8 +: 8] ^ 8'h80;
        w_pad[b*8 +: 8] = 8'h80;
      end
    end
    w_pad[7:0] = w_pad[7:0] ^ 8'h1F;
  end

  // Next-state logic.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:
        if (w_hs)
          w_nxt = last_in ? S_FINAL : S_LOAD;
      S_LOAD:
        if (w_hs) begin
          if (last_in)
            w_nxt = S_FINAL;
          else if (r_cnt == w_nw_last)
            w_nxt = S_WMID;
        end
      S_FINAL:
        w_nxt = w_in_blk ? S_WEND : S_WPAD;
      S_WMID:
        if (input_buffer_ready_clr)
          w_nxt = S_LOAD;
      S_WPAD:
        if (input_buffer_ready_clr)
          w_nxt = S_WEND;
      S_WEND:
        if (w_ibr_done && w_lbb_done)
          w_nxt = S_IDLE;
      default:
        w_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_nxt;
  end

  // Block buffer, counters, sampled fields and handoff flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_lb    <= '0;
      r_rate  <= '0;
      r_size  <= '0;
      r_mode  <= '0;
      r_ibr   <= 1'b0;
      r_lbb   <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= (w_nxt == S_IDLE) || (w_nxt == S_LOAD);
      if (r_ibr && input_buffer_ready_clr)
        r_ibr <= 1'b0;
      if (r_lbb && last_block_in_buffer_clr)
        r_lbb <= 1'b0;
      case (r_state)
        S_IDLE:
          if (w_hs) begin
            r_size       <= output_size_in;
            r_mode       <= operation_mode_in;
            r_rate[W-1:0] <= data_in;
            r_lb         <= last_bytes;
            r_cnt        <= last_in ? CW'(0) : CW'(1);
          end
        S_LOAD:
          if (w_hs) begin
            r_rate[r_cnt*W +: W] <= data_in;
            r_lb <= last_bytes;
            if (!last_in) begin
              if (r_cnt == w_nw_last)
                r_ibr <= 1'b1;
              else
                r_cnt <= r_cnt + CW'(1);
            end
          end
        S_FINAL: begin
          r_rate <= w_fin;
          r_ibr  <= 1'b1;
          if (w_in_blk)
            r_lbb <= 1'b1;
        end
        S_WMID:
          if (input_buffer_ready_clr) begin
            r_rate <= '0;
            r_cnt  <= '0;
          end
        S_WPAD:
          if (input_buffer_ready_clr) begin
            r_rate <= w_pad;
            r_ibr  <= 1'b1;
            r_lbb  <= 1'b1;
          end
        S_WEND:
          if (w_ibr_done && w_lbb_done) begin
            r_rate <= '0;
            r_cnt  <= '0;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_absorb_load_stage.sv
// tb_absorb_load_stage: randomized and directed bench with a
// byte-level SHAKE padding model of the expected blocks.
module tb_absorb_load_stage;

  localparam int W    = 64;
  localparam int R128 = 1344;
  localparam int R256 = 1088;
  localparam int NB   = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    data_in;
  logic            valid_in;
  logic            last_in;
  logic [3:0]      last_bytes;
  logic [31:0]     output_size_in;
  logic [1:0]      operation_mode_in;
  logic            ready_out;
  logic [R128-1:0] rate_output;
  logic [31:0]     output_size;
  logic [1:0]      operation_mode;
  logic            ibr;
  logic            lbb;
  logic            ibr_clr;
  logic            lbb_clr;

  absorb_load_stage #(.W(W), .RATE128(R128), .RATE256(R256)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .data_in                  (data_in),
    .valid_in                 (valid_in),
    .last_in                  (last_in),
    .last_bytes               (last_bytes),
    .output_size_in           (output_size_in),
    .operation_mode_in        (operation_mode_in),
    .ready_out                (ready_out),
    .rate_output              (rate_output),
    .output_size              (output_size),
    .operation_mode           (operation_mode),
    .input_buffer_ready       (ibr),
    .last_block_in_buffer     (lbb),
    .input_buffer_ready_clr   (ibr_clr),
    .last_block_in_buffer_clr (lbb_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [R128-1:0] q_blk[$];
  bit              q_last[$];
  logic [31:0]     q_size[$];
  logic [1:0]      q_mode[$];
  logic [R128-1:0] cap_blk;
  bit              cap_last;
  int              force_delay = -1;
  bit [7:0]        msg[];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk_blk(input string nm, input logic [R128-1:0] act,
                         input logic [R128-1:0] exp);
    int fb;
    checks++;
    if (act !== exp) begin
      errors++;
      fb = 0;
      for (int i = R128/8 - 1; i >= 0; i--)
        if (act[i*8 +: 8] !== exp[i*8 +: 8]) fb = i;
      $display("FAIL %s byte %0d act=%h exp=%h", nm, fb,
               act[fb*8 +: 8], exp[fb*8 +: 8]);
    end
  endtask

  task automatic stop_now(input string nm);
    errors++;
    $display("FAIL timeout %s", nm);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "bench stopped");
  endtask

  // Reference: pad the byte string (0x1F, zeros, 0x80) and cut into blocks.
  task automatic build_exp(input logic [1:0] mode, input logic [31:0] size);
    int L;
    int R;
    int nbk;
    bit [7:0] pb[];
    logic [R128-1:0] b;
    L   = msg.size();
    R   = (mode == 2'b01) ? R256/8 : R128/8;
    nbk = L / R + 1;
    pb  = new[nbk*R];
    for (int i = 0; i < L; i++) pb[i] = msg[i];
    pb[L] = pb[L] ^ 8'h1F;
    pb[nbk*R-1] = pb[nbk*R-1] ^ 8'h80;
    for (int k = 0; k < nbk; k++) begin
      b = '0;
      for (int i = 0; i < R; i++) b[i*8 +: 8] = pb[k*R + i];
      q_blk.push_back(b);
      q_last.push_back(k == nbk - 1);
      q_size.push_back(size);
      q_mode.push_back(mode);
    end
  endtask

  task automatic send(input logic [1:0] mode, input logic [31:0] size,
                      input bit extra0, input bit ffgarb,
                      input int abort_after);
    int L;
    int nw;
    int lb;
    int t;
    logic [W-1:0] d;
    L = msg.size();
    if (L == 0) begin
      nw = 1; lb = 0;
    end else if (L % NB != 0) begin
      nw = (L + NB - 1) / NB; lb = L % NB;
    end else if (extra0) begin
      nw = L / NB + 1; lb = 0;
    end else begin
      nw = L / NB; lb = NB;
    end
    if (abort_after < 0) build_exp(mode, size);
    for (int w = 0; w < nw; w++) begin
      if (abort_after >= 0 && w == abort_after) begin
        valid_in = 1'b0;
        return;
      end
      if ($urandom_range(0, 3) == 0) begin
        valid_in = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      for (int j = 0; j < NB; j++) begin
        if (w*NB + j < L) d[j*8 +: 8] = msg[w*NB + j];
        else if (ffgarb) d[j*8 +: 8] = 8'hFF;
        else d[j*8 +: 8] = 8'($urandom);
      end
      data_in  = d;
      valid_in = 1'b1;
      last_in  = (w == nw - 1);
      last_bytes = (w == nw - 1) ? 4'(lb) : 4'($urandom_range(0, 8));
      output_size_in    = (w == 0) ? size : $urandom;
      operation_mode_in = (w == 0) ? mode : 2'($urandom);
      t = 0;
      while (!ready_out) begin
        @(negedge clk);
        t++;
        if (t > 2000) stop_now("ready_out");
      end
      @(negedge clk);
    end
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q_blk.size() != 0 || !ready_out) begin
      @(negedge clk);
      t++;
      if (t > 5000) stop_now("drain");
    end
  endtask

  // Permute-stage stand-in and compare process.
  initial begin
    logic [R128-1:0] eb;
    bit              el;
    logic [31:0]     es;
    logic [1:0]      em;
    int              d;
    bit              both;
    ibr_clr = 1'b0;
    lbb_clr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && ibr) begin
        if (q_blk.size() == 0) begin
          errors++;
          $display("FAIL unexpected block lbb=%0d", lbb);
          eb = rate_output; el = lbb; es = output_size; em = operation_mode;
        end else begin
          eb = q_blk.pop_front();
          el = q_last.pop_front();
          es = q_size.pop_front();
          em = q_mode.pop_front();
        end
        chk_blk("block", rate_output, eb);
        chk("last_flag", 64'(lbb), 64'(el));
        chk("out_size", 64'(output_size), 64'(es));
        chk("out_mode", 64'(operation_mode), 64'(em));
        chk("ready_pending", 64'(ready_out), 64'(0));
        cap_blk  = rate_output;
        cap_last = lbb;
        d = (force_delay >= 0) ? force_delay : $urandom_range(0, 3);
        repeat (d) begin
          @(negedge clk);
          chk_blk("stable", rate_output, eb);
          chk("ready_hold", 64'(ready_out), 64'(0));
        end
        both = 1'($urandom_range(0, 1));
        ibr_clr = 1'b1;
        if (el && both) lbb_clr = 1'b1;
        @(negedge clk);
        ibr_clr = 1'b0;
        lbb_clr = 1'b0;
        if (el && !both) begin
          lbb_clr = 1'b1;
          @(negedge clk);
          lbb_clr = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [R128-1:0] tmp;
    int L;
    rst = 1'b1;
    valid_in = 1'b0;
    last_in = 1'b0;
    last_bytes = '0;
    data_in = '0;
    output_size_in = '0;
    operation_mode_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready_out), 64'(0));
    chk("rst_ibr", 64'(ibr), 64'(0));
    chk("rst_lbb", 64'(lbb), 64'(0));
    chk("rst_size", 64'(output_size), 64'(0));
    chk("rst_mode", 64'(operation_mode), 64'(0));
    chk_blk("rst_rate", rate_output, '0);
    rst = 1'b0;
    @(negedge clk);

    // "abc", SHAKE128
    msg = new[3];
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send(2'b00, 32'd256, 1'b0, 1'b0, -1);
    tmp = q_blk[0];
    chk("model_abc_lo", 64'(tmp[31:0]), 64'h1F636261);
    chk("model_abc_167", 64'(tmp[167*8 +: 8]), 64'h80);
    chk("abc_final_cycle", 64'(ibr), 64'(0));
    @(negedge clk);
    chk("abc_ibr_lat", 64'(ibr), 64'(1));
    chk("abc_lbb_lat", 64'(lbb), 64'(1));
    drain();
    chk("abc_lo", 64'(cap_blk[63:0]), 64'h1F636261);
    chk("abc_167", 64'(cap_blk[167*8 +: 8]), 64'h80);
    chk("abc_size", 64'(output_size), 64'd256);
    chk("abc_mode", 64'(operation_mode), 64'd0);

    // empty SHAKE256
    msg = new[0];
    send(2'b01, 32'd512, 1'b0, 1'b0, -1);
    drain();
    chk("empty_b0", 64'(cap_blk[7:0]), 64'h1F);
    chk("empty_b135", 64'(cap_blk[135*8 +: 8]), 64'h80);
    chk("empty_upper", 64'(|cap_blk[R128-1:R256]), 64'(0));
    chk("empty_last", 64'(cap_last), 64'(1));

    // 21 full words SHAKE128: data block then padding-only block
    msg = new[168];
    foreach (msg[i]) msg[i] = 8'($urandom);
    send(2'b00, 32'd128, 1'b0, 1'b0, -1);
    drain();
    chk("pad_b0", 64'(cap_blk[7:0]), 64'h1F);
    chk("pad_b167", 64'(cap_blk[167*8 +: 8]), 64'h80);
    chk("pad_last", 64'(cap_last), 64'(1));

    // SHAKE256, 21 words ending with 5 bytes, slow consumer
    msg = new[165];
    foreach (msg[i]) msg[i] = 8'($urandom);
    force_delay = 10;
    send(2'b01, 32'd1000, 1'b0, 1'b0, -1);
    drain();
    force_delay = -1;
    chk("s256_b29", 64'(cap_blk[29*8 +: 8]), 64'h1F);
    chk("s256_b28", 64'(cap_blk[28*8 +: 8]), 64'(msg[164]));
    chk("s256_b135", 64'(cap_blk[135*8 +: 8]), 64'h80);

    // trailing 0xFF garbage must be masked
    msg = new[2];
    msg[0] = 8'hA5; msg[1] = 8'h5A;
    send(2'b00, 32'd64, 1'b0, 1'b1, -1);
    drain();
    chk("mask_word0", 64'(cap_blk[63:0]), 64'h0000_0000_001F_5AA5);

    // abort with reset after 5 words
    msg = new[100];
    foreach (msg[i]) msg[i] = 8'($urandom);
    send(2'b00, 32'd77, 1'b0, 1'b0, 5);
    rst = 1'b1;
    #1;
    chk("abort_ibr", 64'(ibr), 64'(0));
    chk("abort_ready", 64'(ready_out), 64'(0));
    chk("abort_size", 64'(output_size), 64'(0));
    chk_blk("abort_rate", rate_output, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle_ready", 64'(ready_out), 64'(1));
    msg = new[8];
    foreach (msg[i]) msg[i] = 8'($urandom);
    send(2'b00, 32'd99, 1'b0, 1'b0, -1);
    drain();
    tmp = '0;
    for (int i = 0; i < 8; i++) tmp[i*8 +: 8] = msg[i];
    chk("after_rst_w0", 64'(cap_blk[63:0]), tmp[63:0]);
    chk("after_rst_b8", 64'(cap_blk[71:64]), 64'h1F);

    // randomized messages
    for (int n = 0; n < 40; n++) begin
      L = $urandom_range(0, 400);
      if (n % 5 == 0) L = 8 * $urandom_range(0, 45);
      msg = new[L];
      foreach (msg[i]) msg[i] = 8'($urandom);
      send(2'($urandom), $urandom, 1'($urandom), 1'($urandom), -1);
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
